// File: rtl/ac_pkg.sv
// Shared mode and fan-state codes for the climate controller, plus the AUTO band lookup
// and a clamp helper used to keep outlet-target arithmetic from wrapping.
package ac_pkg;

  typedef enum logic [2:0] {
    MODE_OFF       = 3'd0,
    MODE_AUTO      = 3'd1,
    MODE_FAST_COOL = 3'd2,
    MODE_ECO       = 3'd3,
    MODE_HEAT      = 3'd4
  } ac_mode_e;

  typedef enum logic [1:0] {
    FAN_IDLE    = 2'd0,
    FAN_RUN     = 2'd1,
    FAN_LOCKOUT = 2'd2
  } fan_state_e;

  localparam int FAST_COOL_OFFSET = 5;

  // Demand bands shared by AUTO (cooling error) and HEAT (heating error).
  function automatic int auto_band(input int e, input int fan_max);
    if (e <= 0) return 0;
    if (e <= 2) return 1;
    if (e <= 4) return 2;
    return (fan_max < 3) ? fan_max : 3;
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/ac_btn_edge.sv
// Registered rising-edge detector for one push-button: press is high for the single
// cycle in which the button is high and its previous sample was low.
module ac_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prev <= 1'b0;
    else        r_prev <= i_btn;
  end

  assign o_press = i_btn & ~r_prev;

endmodule

// File: rtl/ac_climate_ctrl.sv
// Air-conditioning controller: setpoint entry, mode cycling, ramped fan control with
// compressor off-time lockout. Define HEAT_MODE_EN to add the HEAT mode after ECO.
module ac_climate_ctrl #(
  parameter int TEMP_W         = 7,
  parameter int FAN_W          = 3,
  parameter int SP_MIN         = 18,
  parameter int SP_MAX         = 26,
  parameter int DEADBAND       = 2,
  parameter int RAMP_CYCLES    = 16,
  parameter int MIN_OFF_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button_ac,
  input  logic              button_up,
  input  logic              button_down,
  input  logic [TEMP_W-1:0] temperature,
  output logic [TEMP_W-1:0] setpoint,
  output logic [2:0]        mode,
  output logic [FAN_W-1:0]  fan_speed,
  output logic [TEMP_W-1:0] fan_target,
  output logic              compressor_on,
  output logic              heating
);
  import ac_pkg::*;

  localparam int FAN_MAX  = (1 << FAN_W) - 1;
  localparam int TEMP_MAX = (1 << TEMP_W) - 1;
  localparam int RAMP_W   = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int LOCK_W   = (MIN_OFF_CYCLES > 1) ? $clog2(MIN_OFF_CYCLES) : 1;

  logic                     w_ac_press, w_up_press, w_dn_press;
  logic [TEMP_W-1:0]        r_setpoint;
  logic [2:0]               r_mode, w_mode_nxt;
  logic signed [TEMP_W:0]   r_diff;
  logic signed [TEMP_W+1:0] w_e_cool;
  logic [FAN_W-1:0]         w_req;
  fan_state_e               r_state, w_state_nxt;
  logic [FAN_W-1:0]         r_fan, w_fan_nxt;
  logic [RAMP_W-1:0]        r_ramp, w_ramp_nxt;
  logic [LOCK_W-1:0]        r_lock, w_lock_nxt;
  logic                     w_ramp_done;
  int                       w_step;

  ac_btn_edge u_edge_ac (.clk(clk), .reset(reset), .i_btn(button_ac),   .o_press(w_ac_press));
  ac_btn_edge u_edge_up (.clk(clk), .reset(reset), .i_btn(button_up),   .o_press(w_up_press));
  ac_btn_edge u_edge_dn (.clk(clk), .reset(reset), .i_btn(button_down), .o_press(w_dn_press));

  always_comb begin
    w_mode_nxt = MODE_OFF;
    case (r_mode)
      MODE_OFF:       w_mode_nxt = MODE_AUTO;
      MODE_AUTO:      w_mode_nxt = MODE_FAST_COOL;
      MODE_FAST_COOL: w_mode_nxt = MODE_ECO;
`ifdef HEAT_MODE_EN
      MODE_ECO:       w_mode_nxt = MODE_HEAT;
`else
      MODE_ECO:       w_mode_nxt = MODE_OFF;
`endif
      default:        w_mode_nxt = MODE_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_setpoint <= TEMP_W'(SP_MIN);
      r_mode     <= MODE_OFF;
      r_diff     <= '0;
    end else begin
      if (w_up_press && !w_dn_press && (r_setpoint < TEMP_W'(SP_MAX)))
        r_setpoint <= r_setpoint + TEMP_W'(1);
      else if (w_dn_press && !w_up_press && (r_setpoint > TEMP_W'(SP_MIN)))
        r_setpoint <= r_setpoint - TEMP_W'(1);
      if (w_ac_press) r_mode <= w_mode_nxt;
      r_diff <= $signed({1'b0, temperature}) - $signed({1'b0, r_setpoint});
    end
  end

  // Errors are formed one bit wider than diff so the deadband offset cannot wrap.
  assign w_e_cool = $signed({r_diff[TEMP_W], r_diff}) - $signed((TEMP_W+2)'(DEADBAND));
`ifdef HEAT_MODE_EN
  logic signed [TEMP_W+1:0] w_e_heat;
  assign w_e_heat = -$signed({r_diff[TEMP_W], r_diff}) - $signed((TEMP_W+2)'(DEADBAND));
`endif

  always_comb begin
    w_req = '0;
    case (r_mode)
      MODE_AUTO:      w_req = FAN_W'(auto_band(int'(w_e_cool), FAN_MAX));
      MODE_FAST_COOL: w_req = FAN_W'(FAN_MAX);
      MODE_ECO:       w_req = (w_e_cool > 0) ? FAN_W'(1) : '0;
`ifdef HEAT_MODE_EN
      MODE_HEAT:      w_req = FAN_W'(auto_band(int'(w_e_heat), FAN_MAX));
`endif
      default:        w_req = '0;
    endcase
  end

  assign w_ramp_done = (r_ramp == RAMP_W'(RAMP_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FAN_IDLE;
      r_fan   <= '0;
      r_ramp  <= '0;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fan   <= w_fan_nxt;
      r_ramp  <= w_ramp_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  // The ramp counter runs only while req differs from the applied level; direction is
  // decided at the step itself, so a mid-interval req change just redirects the step.
  always_comb begin
    w_state_nxt = r_state;
    w_fan_nxt   = r_fan;
    w_ramp_nxt  = '0;
    w_lock_nxt  = r_lock;
    case (r_state)
      FAN_IDLE: begin
        if (w_req != '0) begin
          if (w_ramp_done) begin
            w_fan_nxt   = FAN_W'(1);
            w_state_nxt = FAN_RUN;
          end else begin
            w_ramp_nxt = r_ramp + RAMP_W'(1);
          end
        end
      end
      FAN_RUN: begin
        if (r_mode == MODE_OFF) begin
          w_fan_nxt   = '0;
          w_state_nxt = FAN_LOCKOUT;
          w_lock_nxt  = LOCK_W'(MIN_OFF_CYCLES - 1);
        end else if (w_req != r_fan) begin
          if (!w_ramp_done) begin
            w_ramp_nxt = r_ramp + RAMP_W'(1);
          end else if (w_req > r_fan) begin
            w_fan_nxt = r_fan + FAN_W'(1);
          end else begin
            w_fan_nxt = r_fan - FAN_W'(1);
            if (r_fan == FAN_W'(1)) begin
              w_state_nxt = FAN_LOCKOUT;
              w_lock_nxt  = LOCK_W'(MIN_OFF_CYCLES - 1);
            end
          end
        end
      end
      FAN_LOCKOUT: begin
        if (r_lock == '0) w_state_nxt = FAN_IDLE;
        else              w_lock_nxt  = r_lock - LOCK_W'(1);
      end
      default: w_state_nxt = FAN_IDLE;
    endcase
  end

  assign w_step = 2 * int'(r_fan) - 1;

  always_comb begin
    fan_target = '0;
    if (r_fan != '0) begin
      if (r_mode == MODE_FAST_COOL)
        fan_target = TEMP_W'(clamp(int'(r_setpoint) - FAST_COOL_OFFSET, TEMP_MAX));
`ifdef HEAT_MODE_EN
      else if (r_mode == MODE_HEAT)
        fan_target = TEMP_W'(clamp(int'(r_setpoint) + w_step, TEMP_MAX));
`endif
      else
        fan_target = TEMP_W'(clamp(int'(r_setpoint) - w_step, TEMP_MAX));
    end
  end

  assign setpoint      = r_setpoint;
  assign mode          = r_mode;
  assign fan_speed     = r_fan;
  assign compressor_on = (r_fan != '0);
`ifdef HEAT_MODE_EN
  assign heating       = (r_mode == MODE_HEAT) && (r_fan != '0);
`else
  assign heating       = 1'b0;
`endif

endmodule

// File: doc/ac_climate_ctrl.md
# ac_climate_ctrl

Parametrised next-generation air-conditioning controller with setpoint entry, mode selection, fan-speed ramping and compressor short-cycle protection. It replaces the fixed-width single-mode-set controller at the top of the climate path. It takes raw push-buttons and a measured temperature, and drives fan speed, outlet target temperature and compressor enable. New over the previous generation: configurable limits and widths, rate-limited fan changes, a minimum compressor off-time and an optional heating mode.

## Interface
- TEMP_W, 7: width of temperature, setpoint and outlet target.
- FAN_W, 3: fan speed width; FAN_MAX = 2^FAN_W − 1.
- SP_MIN, 18: lowest setpoint; also the reset setpoint.
- SP_MAX, 26: highest setpoint.
- DEADBAND, 2: no demand while |temperature − setpoint| ≤ DEADBAND.
- RAMP_CYCLES, 16: cycles per single fan step (≥ 1).
- MIN_OFF_CYCLES, 64: compressor lockout after switching off (≥ 1).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- button_ac  in  1  mode button (level; edge-detected internally).
- button_up  in  1  setpoint increment button.
- button_down  in  1  setpoint decrement button.
- temperature  in  TEMP_W  measured room temperature, unsigned.
- setpoint  out  TEMP_W  registered user setpoint.
- mode  out  3  current mode code.
- fan_speed  out  FAN_W  applied fan level.
- fan_target  out  TEMP_W  outlet target temperature.
- compressor_on  out  1  high whenever fan_speed ≠ 0.
- heating  out  1  high when the active demand is heating.

## Operation
- Reset values: setpoint = SP_MIN; mode = OFF; fan_speed = 0; fan_target = 0; compressor_on = 0; heating = 0. All edge-history, ramp and lockout registers are 0, so there is no lockout after reset.
- Button edge detection: press = button & ~prev, with prev registered per button.
- Setpoint update:
  - Up and down pressed in the same cycle: no change.
  - Up at SP_MAX or down at SP_MIN: saturates, no change.
  - Otherwise the setpoint steps ±1.
- Mode cycle on a button_ac press: OFF(0) → AUTO(1) → FAST_COOL(2) → ECO(3) → OFF.
- diff is a registered signed value, TEMP_W+1 bits, equal to temperature − setpoint.
- Requested level req, where e = diff − DEADBAND:
  - OFF: req = 0.
  - AUTO: req = 0 if e ≤ 0; 1 if e in 1..2; 2 if e in 3..4; otherwise min(3, FAN_MAX).
  - FAST_COOL: req = FAN_MAX, unconditionally.
  - ECO: req = 1 if e > 0, else 0.
- Outlet target:
  - Cooling: fan_target = setpoint − (2·fan_speed − 1), clamped at 0.
  - FAST_COOL: fan_target = setpoint − 5, clamped at 0.
  - fan_speed = 0: fan_target = 0.
- Fan/compressor state machine:
  - IDLE: fan_speed = 0, no lockout. Go to RUN when req > 0 and the ramp interval expires.
  - RUN: fan_speed steps one level toward req per ramp interval. Go to LOCKOUT when fan_speed reaches 0.
  - LOCKOUT: fan_speed held at 0; counter loaded with MIN_OFF_CYCLES − 1 and decremented each cycle. Go to IDLE when the counter reaches 0. req is ignored throughout.
- Ramp counter:
  - Counts only while req ≠ fan_speed; held at 0 while they are equal.
  - When it reaches RAMP_CYCLES − 1, fan_speed steps and the counter clears.
  - If req changes mid-interval, the count continues and the direction is re-evaluated at the step.
- A mode change to OFF forces fan_speed = 0 at the next edge, bypassing the ramp, and enters LOCKOUT.
- No arithmetic wraps: all subtractions are clamped at 0 and all additions at 2^TEMP_W − 1.

## Timing
- Button high with prev low at edge N: setpoint or mode updates at edge N. A held button produces exactly one step.
- temperature and setpoint → diff: 1 cycle. req is combinational from diff and mode.
- First fan step occurs RAMP_CYCLES edges after req first differs from fan_speed. Full ramp 0 → k takes k·RAMP_CYCLES cycles.
- fan_target and compressor_on follow fan_speed combinationally from registers; they have no extra latency.
- Reset asserted mid-ramp or mid-lockout: all outputs take their reset values immediately. Release is synchronous to the next clk edge.

## Configuration
- HEAT_MODE_EN defined:
  - The mode cycle gains HEAT(4): ECO → HEAT → OFF.
  - In HEAT, req uses the AUTO bands applied to (−diff − DEADBAND).
  - heating = 1 whenever mode = HEAT and fan_speed ≠ 0.
  - fan_target = setpoint + (2·fan_speed − 1), saturating.
- Undefined: ECO → OFF, and heating is tied to 0.

## Structure
- Shared package ac_pkg holds the mode codes (OFF, AUTO, FAST_COOL, ECO, HEAT) and the fan state codes (IDLE, RUN, LOCKOUT).
- One sub-module, ac_btn_edge, provides the registered rising-edge detector. It is instantiated three times.

## Test plan
Bench parameters: RAMP_CYCLES = 4, MIN_OFF_CYCLES = 8, defaults otherwise.

1. Hold button_up for 20 cycles, then pulse it 10 more times → setpoint goes 18 → 19 on the first press and saturates at 26. Simultaneous up+down at 22 → stays 22.
2. Setpoint 22, mode AUTO, temperature 29 (e = 5) → req = 3; fan_speed goes 1, 2, 3 at 4-cycle spacing; fan_target = 17 at speed 3; compressor_on = 1.
3. Running at speed 3, press button_ac to reach OFF → fan_speed = 0 next edge. Return to AUTO with demand → fan_speed stays 0 for 8 cycles, then 4 more before stepping to 1.
4. FAST_COOL with setpoint 18, temperature 18 → ramps to 7; fan_target = 13.
5. With HEAT_MODE_EN: setpoint 24, temperature 19, mode HEAT → req = 2; heating = 1; fan_target = 27 at speed 2. Without the macro, four presses return the mode to OFF.
6. Assert reset during LOCKOUT → all outputs at reset values. After release, a demand ramps with no lockout delay.
